// File: rtl/hadamard_gate_pipelined.sv
// Pipelined Hadamard on one qubit of a 3-qubit complex state vector.
// Stage 1 forms pair sums/differences; stage 2 scales by 1/sqrt2, rounds and saturates.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 14
`endif

module hadamard_gate_pipelined #(
   parameter int TARGET    = 0,
   parameter int INV_SQRT2 =
      int'(((64'd3037000500 << `FRAC_WIDTH) + 64'h8000_0000) >> 32)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic signed [`TOTAL_WIDTH-1:0] in_000_r,
   input  logic signed [`TOTAL_WIDTH-1:0] in_000_i,
   input  logic signed [`TOTAL_WIDTH-1:0] in_001_r,
   input  logic signed [`TOTAL_WIDTH-1:0] in_001_i,
   input  logic signed [`TOTAL_WIDTH-1:0] in_010_r,
   input  logic signed [`TOTAL_WIDTH-1:0] in_010_i,
   input  logic signed [`TOTAL_WIDTH-1:0] in_011_r,
   input  logic signed [`TOTAL_WIDTH-1:0] in_011_i,
   input  logic signed [`TOTAL_WIDTH-1:0] in_100_r,
   input  logic signed [`TOTAL_WIDTH-1:0] in_100_i,
   input  logic signed [`TOTAL_WIDTH-1:0] in_101_r,
   input  logic signed [`TOTAL_WIDTH-1:0] in_101_i,
   input  logic signed [`TOTAL_WIDTH-1:0] in_110_r,
   input  logic signed [`TOTAL_WIDTH-1:0] in_110_i,
   input  logic signed [`TOTAL_WIDTH-1:0] in_111_r,
   input  logic signed [`TOTAL_WIDTH-1:0] in_111_i,
   output logic                           out_valid,
   output logic signed [`TOTAL_WIDTH-1:0] out_000_r,
   output logic signed [`TOTAL_WIDTH-1:0] out_000_i,
   output logic signed [`TOTAL_WIDTH-1:0] out_001_r,
   output logic signed [`TOTAL_WIDTH-1:0] out_001_i,
   output logic signed [`TOTAL_WIDTH-1:0] out_010_r,
   output logic signed [`TOTAL_WIDTH-1:0] out_010_i,
   output logic signed [`TOTAL_WIDTH-1:0] out_011_r,
   output logic signed [`TOTAL_WIDTH-1:0] out_011_i,
   output logic signed [`TOTAL_WIDTH-1:0] out_100_r,
   output logic signed [`TOTAL_WIDTH-1:0] out_100_i,
   output logic signed [`TOTAL_WIDTH-1:0] out_101_r,
   output logic signed [`TOTAL_WIDTH-1:0] out_101_i,
   output logic signed [`TOTAL_WIDTH-1:0] out_110_r,
   output logic signed [`TOTAL_WIDTH-1:0] out_110_i,
   output logic signed [`TOTAL_WIDTH-1:0] out_111_r,
   output logic signed [`TOTAL_WIDTH-1:0] out_111_i,
   output logic                           sat_flag
);
   localparam int W    = `TOTAL_WIDTH;
   localparam int F    = `FRAC_WIDTH;
   localparam int MASK = (1 << TARGET) - 1;

   typedef logic signed [W-1:0] word_t;
   typedef logic signed [W:0]   wide_t;
   typedef logic signed [2*W:0] prod_t;

   localparam prod_t K    = prod_t'(INV_SQRT2);
   localparam prod_t HALF = prod_t'(1) << (F - 1);
   localparam prod_t MAXV = (prod_t'(1) << (W - 1)) - prod_t'(1);
   localparam prod_t MINV = -(prod_t'(1) << (W - 1));

   // Returns {saturated, value}; the shift on a signed product floors.
   function automatic logic [W:0] scale(input wide_t x);
      prod_t p;
      prod_t r;
      p = prod_t'(x) * K;
      r = (p + HALF) >>> F;
      if (r > MAXV)
         scale = {1'b1, word_t'(MAXV)};
      else if (r < MINV)
         scale = {1'b1, word_t'(MINV)};
      else
         scale = {1'b0, word_t'(r)};
   endfunction

   word_t in_r [8];
   word_t in_i [8];
   word_t res_r [8];
   word_t res_i [8];
   word_t q_r [8];
   word_t q_i [8];
   logic  sat_r [8];
   logic  sat_i [8];
   logic  any_sat;
   logic  v1;

   assign in_r[0] = in_000_r;
   assign in_i[0] = in_000_i;
   assign in_r[1] = in_001_r;
   assign in_i[1] = in_001_i;
   assign in_r[2] = in_010_r;
   assign in_i[2] = in_010_i;
   assign in_r[3] = in_011_r;
   assign in_i[3] = in_011_i;
   assign in_r[4] = in_100_r;
   assign in_i[4] = in_100_i;
   assign in_r[5] = in_101_r;
   assign in_i[5] = in_101_i;
   assign in_r[6] = in_110_r;
   assign in_i[6] = in_110_i;
   assign in_r[7] = in_111_r;
   assign in_i[7] = in_111_i;

   if (TARGET < 0 || TARGET > 2) begin : g_bad_target
      $error("hadamard_gate_pipelined: TARGET must be 0, 1 or 2");
   end

   // Pair j: insert a 0 at bit TARGET to get a, set it to get b.
   for (genvar j = 0; j < 4; j++) begin : g_pair
      localparam int A = ((j >> TARGET) << (TARGET + 1)) | (j & MASK);
      localparam int B = A | (1 << TARGET);

      wide_t sr, dr, si, di;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sr <= '0;
            dr <= '0;
            si <= '0;
            di <= '0;
         end else if (in_valid) begin
            sr <= wide_t'(in_r[A]) + wide_t'(in_r[B]);
            dr <= wide_t'(in_r[A]) - wide_t'(in_r[B]);
            si <= wide_t'(in_i[A]) + wide_t'(in_i[B]);
            di <= wide_t'(in_i[A]) - wide_t'(in_i[B]);
         end
      end

      assign {sat_r[A], res_r[A]} = scale(sr);
      assign {sat_r[B], res_r[B]} = scale(dr);
      assign {sat_i[A], res_i[A]} = scale(si);
      assign {sat_i[B], res_i[B]} = scale(di);
   end

   always_comb begin
      any_sat = 1'b0;
      for (int k = 0; k < 8; k++)
         any_sat = any_sat | sat_r[k] | sat_i[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
         q_r       <= '{default: '0};
         q_i       <= '{default: '0};
      end else begin
         v1        <= in_valid;
         out_valid <= v1;
         sat_flag  <= v1 & any_sat;
         if (v1) begin
            q_r <= res_r;
            q_i <= res_i;
         end
      end
   end

   assign out_000_r = q_r[0];
   assign out_000_i = q_i[0];
   assign out_001_r = q_r[1];
   assign out_001_i = q_i[1];
   assign out_010_r = q_r[2];
   assign out_010_i = q_i[2];
   assign out_011_r = q_r[3];
   assign out_011_i = q_i[3];
   assign out_100_r = q_r[4];
   assign out_100_i = q_i[4];
   assign out_101_r = q_r[5];
   assign out_101_i = q_i[5];
   assign out_110_r = q_r[6];
   assign out_110_i = q_i[6];
   assign out_111_r = q_r[7];
   assign out_111_i = q_i[7];

endmodule

// File: doc/hadamard_gate_pipelined.md
Name: hadamard_gate_pipelined

Overview:
- Pipelined single-qubit Hadamard stage for the 3-qubit QFT datapath. Operates on the full 8-amplitude complex state vector.
- Instantiated as the last Hadamard before the final qubit-reversal swap stage. Its outputs drive the swap stage's inputs directly.
- For each basis pair (a, b) that differs only in bit TARGET of the state label: out_a = (a+b)/√2 and out_b = (a−b)/√2. Real and imaginary parts are processed independently.
- 2-cycle latency, valid-qualified, saturating fixed-point arithmetic.

Parameters:
- TARGET, 0: target qubit bit position in the 3-bit state label (0, 1 or 2). Any other value is a compile-time error.
- INV_SQRT2, round(0.70710678 × 2^`FRAC_WIDTH): 1/√2 constant in the shared fixed-point format. With 16/14 format it is 11585.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input amplitudes valid this cycle
- in_XXX_r, in_XXX_i (XXX = 000..111)  in  `TOTAL_WIDTH each, signed  input amplitudes, `FRAC_WIDTH fraction bits
- out_valid  out  1  output amplitudes valid
- out_XXX_r, out_XXX_i (XXX = 000..111)  out  `TOTAL_WIDTH each, signed  transformed amplitudes
- sat_flag  out  1  asserted with out_valid if any of the 16 output words saturated

Behaviour:
- Widths: W = `TOTAL_WIDTH and F = `FRAC_WIDTH, both taken from fixed_point_params.vh.
- Reset: one clock and one asynchronous active-low reset (rst_n), with no synchronous reset.
  - Asserting rst_n low clears every pipeline register, all outputs, out_valid and sat_flag to 0 immediately, regardless of clk.
  - Reset mid-operation discards all in-flight data.
  - The first capture occurs on the first rising clk edge after rst_n deasserts.
- Pairing: partner of index k is k ^ (1 << TARGET). For each pair, the lower index is "a" and the higher is "b". Selection is done with generate; there is no runtime mux.
- Stage 1 (edge 1):
  - When in_valid=1, register s = a+b and d = a−b at W+1 bits, sign-extended, with no overflow possible.
  - v1 <= in_valid.
  - When in_valid=0, stage-1 data registers hold their previous value.
- Stage 2 (edge 2):
  - When v1=1: p = s × INV_SQRT2, full precision at W+1+W bits.
  - Round half-up: r = (p + 2^(F−1)) >>> F, arithmetic shift, i.e. floor.
  - Saturate r to [−2^(W−1), 2^(W−1)−1] and register the result.
  - The same applies to d.
  - sat_flag <= OR of the 16 saturation events. out_valid <= v1.
  - When v1=0: data registers and outputs hold the last valid result, sat_flag <= 0, out_valid <= 0.
- Latency: exactly 2 cycles from in_valid to out_valid.
- Throughput: one state vector per cycle. Back-to-back valids are fully pipelined and the block has no backpressure.
- Bubbles: gaps in in_valid propagate as gaps in out_valid 2 cycles later.
- Unrelated indices: all pairs are transformed, so there is no passthrough.
- Arithmetic is purely signed: no unsigned intermediates, no truncation before rounding.

Test Plan (W=16, F=14, INV_SQRT2=11585, TARGET=0 unless stated):
- Basis state: in_000_r=16384, all others 0, in_valid pulse → 2 cycles later out_valid=1 for one cycle, out_000_r=out_001_r=11585, all others 0, sat_flag=0.
- Rounding: a=b=11585 on pair 000/001 real → out_000_r=16383, out_001_r=0. Then a=1, b=0 → out_000_r=1, out_001_r=1. Then a=−1, b=0 → out_000_r=−1, out_001_r=−1.
- Saturation: a=b=32767 → out_000_r=32767, sat_flag=1. Then a=b=−32768 → out_000_r=−32768, sat_flag=1. The diff outputs are 0 in both cases.
- TARGET=2: in_010_i=16384, in_110_i=−16384 → out_010_i=0, out_110_i=23170 (sat_flag=0), all other outputs 0.
- Streaming: 5 consecutive valid vectors followed by a 2-cycle gap and 1 more vector → out_valid pattern 11111 0 0 1 beginning at cycle 2. Each result is correct and in order, and outputs hold between valids.
- Reset: assert rst_n low asynchronously with 2 vectors in flight → outputs, out_valid and sat_flag go to 0 without a clock edge. No stale vector emerges after release. The first post-reset vector appears exactly 2 cycles after its in_valid.
